// File: rtl/saa_cfg_pkg.sv
// Shared constants, state encoding and table entry layout for the SAA7111A
// power-up configuration sequencer.
package saa_cfg_pkg;

  localparam logic [6:0] DEV_ADDR    = 7'h24;
  localparam logic [7:0] DEV_WR_BYTE = {DEV_ADDR, 1'b0};
  localparam int         NUM_REGS    = 24;
  localparam int         ENTRY_W     = 16;

  typedef enum logic [3:0] {
    ST_WAIT_PWR,
    ST_IDLE,
    ST_SEND_DEV,
    ST_WAIT_DEV,
    ST_SEND_SUB,
    ST_WAIT_SUB,
    ST_SEND_DAT,
    ST_WAIT_DAT,
    ST_NEXT,
    ST_BACKOFF,
    ST_DONE,
    ST_ERROR
  } state_t;

  typedef struct packed {
    logic [7:0] sub_addr;
    logic [7:0] data;
  } entry_t;

endpackage

// File: rtl/saa_cfg_if.sv
// Command/response handshake between the configuration sequencer and the
// byte-level I2C master engine.
interface saa_cfg_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_start;
  logic       cmd_stop;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_nack;

  modport master (
    output cmd_valid, cmd_start, cmd_stop, cmd_data,
    input  cmd_ready, rsp_valid, rsp_nack
  );

  modport slave (
    input  cmd_valid, cmd_start, cmd_stop, cmd_data,
    output cmd_ready, rsp_valid, rsp_nack
  );

endinterface

// File: rtl/saa_cfg_rom.sv
// Default SAA7111A register table: index -> {sub-address, data}.
// Indices past the end of the table read as all zeros.
module saa_cfg_rom
  import saa_cfg_pkg::*;
(
  input  logic [4:0]         idx,
  output logic [ENTRY_W-1:0] entry
);

  logic [7:0] data;

  always_comb begin
    data = 8'h00;
    case (idx)
      5'h01: data = 8'hC0;
      5'h02: data = 8'h23;
      5'h05: data = 8'hEB;
      5'h06: data = 8'hE0;
      5'h07: data = 8'h88;
      5'h08: data = 8'h01;
      5'h09: data = 8'h80;
      5'h0A: data = 8'h47;
      5'h0B: data = 8'h40;
      5'h0D: data = 8'h01;
      5'h10: data = 8'h0C;
      5'h11: data = 8'h09;
      default: data = 8'h00;
    endcase
  end

  assign entry = (int'(idx) < NUM_REGS) ? {3'b000, idx, data} : '0;

endmodule

// File: rtl/saa_cfg_sequencer.sv
// Walks the register table after power-up, issuing one START..STOP write per
// entry to the I2C byte engine, with NACK back-off, bounded retry and status.
module saa_cfg_sequencer
  import saa_cfg_pkg::*;
#(
  parameter int POWERUP_CYCLES = 50000,
  parameter int BACKOFF_CYCLES = 5000,
  parameter int MAX_RETRY      = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [4:0]   err_index,
  saa_cfg_if.master    eng
);

  localparam int CNT_MAX = (POWERUP_CYCLES > BACKOFF_CYCLES) ? POWERUP_CYCLES : BACKOFF_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_t               state, state_d;
  logic [4:0]           idx, idx_d;
  logic [RETRY_W-1:0]   retry, retry_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  entry_t               rom_entry;

  saa_cfg_rom u_rom (
    .idx   (idx),
    .entry (rom_entry)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed by the combinational block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_WAIT_PWR;
      idx   <= '0;
      retry <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      retry <= retry_d;
      cnt   <= cnt_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    retry_d = retry;
    cnt_d   = cnt;

    case (state)
      ST_WAIT_PWR: begin
        if (cnt == CNT_W'(POWERUP_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      ST_IDLE: begin
        idx_d   = '0;
        retry_d = '0;
        state_d = ST_SEND_DEV;
      end
      ST_SEND_DEV: if (eng.cmd_ready) state_d = ST_WAIT_DEV;
      ST_WAIT_DEV: if (eng.rsp_valid) state_d = eng.rsp_nack ? ST_BACKOFF : ST_SEND_SUB;
      ST_SEND_SUB: if (eng.cmd_ready) state_d = ST_WAIT_SUB;
      ST_WAIT_SUB: if (eng.rsp_valid) state_d = eng.rsp_nack ? ST_BACKOFF : ST_SEND_DAT;
      ST_SEND_DAT: if (eng.cmd_ready) state_d = ST_WAIT_DAT;
      ST_WAIT_DAT: if (eng.rsp_valid) state_d = eng.rsp_nack ? ST_BACKOFF : ST_NEXT;
      ST_NEXT: begin
        retry_d = '0;
        if (idx == 5'(NUM_REGS - 1)) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx + 5'd1;
          state_d = ST_SEND_DEV;
        end
      end
      ST_BACKOFF: begin
        // Counter is zero on entry: it is cleared whenever a wait state exits.
        if (cnt == CNT_W'(BACKOFF_CYCLES - 1)) begin
          cnt_d = '0;
          if (int'(retry) < MAX_RETRY) begin
            retry_d = retry + 1'b1;
            state_d = ST_SEND_DEV;
          end else begin
            state_d = ST_ERROR;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      ST_DONE, ST_ERROR: if (start) state_d = ST_IDLE;
      default: state_d = ST_WAIT_PWR;
    endcase
  end

  // Status and command fields are decoded from the registered state, so they
  // stay stable for as long as a command waits for cmd_ready.
  always_comb begin
    eng.cmd_valid = 1'b0;
    eng.cmd_start = 1'b0;
    eng.cmd_stop  = 1'b0;
    eng.cmd_data  = 8'h00;
    case (state)
      ST_SEND_DEV: begin
        eng.cmd_valid = 1'b1;
        eng.cmd_start = 1'b1;
        eng.cmd_data  = DEV_WR_BYTE;
      end
      ST_SEND_SUB: begin
        eng.cmd_valid = 1'b1;
        eng.cmd_data  = rom_entry.sub_addr;
      end
      ST_SEND_DAT: begin
        eng.cmd_valid = 1'b1;
        eng.cmd_stop  = 1'b1;
        eng.cmd_data  = rom_entry.data;
      end
      default: ;
    endcase
  end

  assign busy      = !(state inside {ST_WAIT_PWR, ST_IDLE, ST_DONE, ST_ERROR});
  assign done      = (state == ST_DONE);
  assign error     = (state == ST_ERROR);
  assign err_index = (state == ST_ERROR) ? idx : 5'd0;

endmodule

// File: tb/tb_saa_cfg_sequencer.sv
// Self-checking bench: engine model with an expected-command scoreboard,
// a scenario table for the NACK/retry cases, and hand-written corner sequences.
`timescale 1ns/1ps
module tb_saa_cfg_sequencer;
  import saa_cfg_pkg::*;

  localparam int P   = 50;
  localparam int B   = 20;
  localparam int R   = 3;
  localparam int LAT = 3;
  localparam int BUDGET = 5000;

  typedef struct {
    logic       start;
    logic       stop;
    logic [7:0] data;
    logic       nack;
  } cmd_t;

  typedef struct {
    int         pos;
    int         nidx;
    int         ncount;
    logic       exp_done;
    logic       exp_error;
    logic [4:0] exp_err_index;
    int         exp_cmds;
  } scen_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, error;
  logic [4:0] err_index;

  saa_cfg_if bus ();

  saa_cfg_sequencer #(
    .POWERUP_CYCLES (P),
    .BACKOFF_CYCLES (B),
    .MAX_RETRY      (R)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .err_index (err_index),
    .eng       (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] ref_dat [0:NUM_REGS-1] = '{
    8'h00, 8'hC0, 8'h23, 8'h00, 8'h00, 8'hEB, 8'hE0, 8'h88,
    8'h01, 8'h80, 8'h47, 8'h40, 8'h00, 8'h01, 8'h00, 8'h00,
    8'h0C, 8'h09, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  int   errors = 0;
  int   checks = 0;
  cmd_t exp_q [$];

  int   cyc = 0, pend = 0, xfers = 0, stall_req = 0, stall_left = 0, last_nack_cyc = 0;
  logic pend_nack = 1'b0, held_valid = 1'b0, gap_armed = 1'b0, mark_hit = 1'b0;
  logic [9:0] held = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected command stream for one full run, with the NACK decision per byte.
  task automatic build_seq(input int pos, input int nidx, input int ncount);
    int   used, tries;
    logic ok, nacked;
    cmd_t c;
    exp_q.delete();
    for (int i = 0; i < NUM_REGS; i++) begin
      used = 0; tries = 0; ok = 1'b0;
      while (!ok) begin
        nacked = 1'b0;
        for (int p = 0; p < 3 && !nacked; p++) begin
          c.start = (p == 0);
          c.stop  = (p == 2);
          c.data  = (p == 0) ? 8'h48 : (p == 1) ? 8'(i) : ref_dat[i];
          c.nack  = (p == pos) && (nidx < 0 || i == nidx) && (used < ncount);
          if (c.nack) begin used++; nacked = 1'b1; end
          exp_q.push_back(c);
        end
        if (!nacked) ok = 1'b1;
        else begin
          tries++;
          if (tries > R) return;
        end
      end
    end
  endtask

  // NOTE: the engine model drives on the falling edge with blocking
  // assignments, so the DUT sees settled inputs at every rising edge.
  always @(negedge clk) begin
    cmd_t c;
    cyc++;
    if (!rst_n) begin
      bus.cmd_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      bus.rsp_nack  = 1'b0;
      pend          = 0;
      held_valid    = 1'b0;
      stall_left    = 0;
    end else begin
      bus.rsp_valid = 1'b0;
      bus.rsp_nack  = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.rsp_valid = 1'b1;
          bus.rsp_nack  = pend_nack;
          if (pend_nack) begin last_nack_cyc = cyc; gap_armed = 1'b1; end
        end
      end
      if (bus.cmd_ready) begin
        bus.cmd_ready = 1'b0;
        check("valid_drop", {31'b0, bus.cmd_valid}, 32'd0);
      end else if (held_valid || bus.cmd_valid) begin
        if (gap_armed) begin
          check("backoff_gap", cyc - last_nack_cyc, B + 1);
          gap_armed = 1'b0;
        end
        if (!held_valid) begin
          held       = {bus.cmd_start, bus.cmd_stop, bus.cmd_data};
          held_valid = 1'b1;
          stall_left = stall_req;
          stall_req  = 0;
        end else begin
          check("stall_stable", {bus.cmd_valid, bus.cmd_start, bus.cmd_stop, bus.cmd_data},
                {1'b1, held});
        end
        if (stall_left > 0) begin
          stall_left--;
        end else begin
          bus.cmd_ready = 1'b1;
          held_valid    = 1'b0;
          xfers++;
          if (exp_q.size() == 0) begin
            check("extra_cmd", {22'b0, bus.cmd_start, bus.cmd_stop, bus.cmd_data}, 32'hFFFF);
            pend_nack = 1'b0;
          end else begin
            c = exp_q.pop_front();
            check("cmd", {bus.cmd_start, bus.cmd_stop, bus.cmd_data}, {c.start, c.stop, c.data});
            pend_nack = c.nack;
            if (!c.start && !c.stop && c.data == 8'h0A) mark_hit = 1'b1;
          end
          pend = LAT;
        end
      end
    end
  end

  task automatic powerup();
    int n;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (!bus.cmd_valid && n < P + 100) begin
      @(negedge clk);
      n++;
    end
    check("powerup_delay", n, P + 1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_clears", {busy, done, error, err_index}, 32'd0);
  endtask

  task automatic wait_finish();
    int n;
    n = 0;
    while (!(done || error) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("finish_in_budget", {31'b0, done | error}, 32'd1);
    repeat (B + 10) @(negedge clk);
    check("quiet_after", {30'b0, bus.cmd_valid, busy}, 32'd0);
  endtask

  initial begin
    scen_t tbl [5];
    int    n;
    tbl[0] = '{pos: 0, nidx: -1, ncount: 0,  exp_done: 1'b1, exp_error: 1'b0, exp_err_index: 5'd0,  exp_cmds: 72};
    tbl[1] = '{pos: 1, nidx: 3,  ncount: 1,  exp_done: 1'b1, exp_error: 1'b0, exp_err_index: 5'd0,  exp_cmds: 74};
    tbl[2] = '{pos: 0, nidx: -1, ncount: 99, exp_done: 1'b0, exp_error: 1'b1, exp_err_index: 5'd0,  exp_cmds: 4};
    tbl[3] = '{pos: 2, nidx: 23, ncount: 99, exp_done: 1'b0, exp_error: 1'b1, exp_err_index: 5'd23, exp_cmds: 81};
    tbl[4] = '{pos: 1, nidx: 7,  ncount: 3,  exp_done: 1'b1, exp_error: 1'b0, exp_err_index: 5'd0,  exp_cmds: 78};

    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_nack  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy, done, error, err_index, bus.cmd_valid, bus.cmd_start,
                            bus.cmd_stop, bus.cmd_data}, 32'd0);

    for (int s = 0; s < 5; s++) begin
      build_seq(tbl[s].pos, tbl[s].nidx, tbl[s].ncount);
      xfers     = 0;
      gap_armed = 1'b0;
      if (s == 0) powerup();
      else        pulse_start();
      wait_finish();
      check("done",      {31'b0, done},  {31'b0, tbl[s].exp_done});
      check("error",     {31'b0, error}, {31'b0, tbl[s].exp_error});
      check("err_index", {27'b0, err_index}, {27'b0, tbl[s].exp_err_index});
      check("cmd_count", xfers, tbl[s].exp_cmds);
      check("queue_empty", exp_q.size(), 0);
    end

    // Stalled engine with a start pulse while busy.
    build_seq(0, -1, 0);
    xfers     = 0;
    gap_armed = 1'b0;
    stall_req = 20;
    pulse_start();
    n = 0;
    while (!held_valid && n < 100) begin @(negedge clk); n++; end
    check("stall_seen", {31'b0, held_valid}, 32'd1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_during_stall", {31'b0, busy}, 32'd1);
    wait_finish();
    check("stall_done", {30'b0, done, error}, 32'd2);
    check("stall_cmd_count", xfers, 72);
    check("stall_queue_empty", exp_q.size(), 0);

    // Reset while waiting on the sub-address response of entry 10.
    build_seq(0, -1, 0);
    xfers    = 0;
    mark_hit = 1'b0;
    pulse_start();
    n = 0;
    while (!mark_hit && n < BUDGET) begin @(posedge clk); n++; end
    check("reached_idx10", {31'b0, mark_hit}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", {busy, done, error, err_index, bus.cmd_valid,
                                     bus.cmd_start, bus.cmd_stop, bus.cmd_data}, 32'd0);
    repeat (2) @(negedge clk);
    build_seq(0, -1, 0);
    xfers     = 0;
    gap_armed = 1'b0;
    powerup();
    wait_finish();
    check("rerun_done", {30'b0, done, error}, 32'd2);
    check("rerun_cmd_count", xfers, 72);
    check("rerun_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
